axi_burst_mem_slave: RTL and testbench
======================================

// Module: axi_burst_mem_slave
// PURPOSE
//  Word-addressed AXI4-style memory slave with true INCR bursts, byte strobes and error responses.
//  Independent write (AW/W/B) and read (AR/R) FSMs run concurrently at one beat/cycle.
//  Used as the behavioural on-chip memory behind AXI masters in block and top-level benches.
//  Drop-in successor to the single-address slave: burst beats advance the address per beat.
// PARAMETERS
//  ADDR_WIDTH  32    AXI address width; 1 address increment = 1 data word
//  DATA_WIDTH  32    data bus width, multiple of 8
//  MEM_DEPTH   1024  number of DATA_WIDTH words; power of 2, >=2
// PORTS
//  clk      in   1               rising-edge clock
//  rst_n    in   1               asynchronous active-low reset
//  awaddr   in   ADDR_WIDTH      write burst start word address
//  awlen    in   8               write beats minus 1
//  awvalid  in   1  / awready out 1   write address handshake
//  wdata    in   DATA_WIDTH      write data
//  wstrb    in   DATA_WIDTH/8    byte enables for wdata
//  wvalid   in   1  / wready  out 1   write data handshake
//  wlast    in   1               master's final write beat marker
//  bresp    out  2               write response: 2'b00 OKAY, 2'b10 SLVERR
//  bvalid   out  1  / bready  in  1   write response handshake
//  araddr   in   ADDR_WIDTH      read burst start word address
//  arlen    in   8               read beats minus 1
//  arvalid  in   1  / arready out 1   read address handshake
//  rdata    out  DATA_WIDTH      read data
//  rresp    out  2               per-beat read response: 2'b00 OKAY, 2'b10 SLVERR
//  rvalid   out  1  / rready  in  1   read data handshake
//  rlast    out  1               high on final read beat
// BEHAVIOUR
//  Reset (rst_n low, any time): all outputs 0, both FSMs to IDLE. Memory contents undefined.
//  Reset mid-burst abandons the burst: no bvalid, no further R beats. Beats already written stay.
//  Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
//   W_IDLE: awready=1 (from first edge after reset release). On AW handshake latch addr and len.
//     Clear err, go W_DATA. awready=0 in all other states.
//   W_DATA: wready=1. Each wvalid&&wready beat writes only the bytes with wstrb[i]=1 to mem[addr].
//     Then addr+1 and beat count+1.
//   Beat with wlast: go W_RESP. If beat count != awlen, err=1.
//   Beats after awlen+1 without wlast are dropped (no write) and set err=1. Wait for wlast.
//   W_RESP: bvalid=1, bresp = err ? 2'b10 : 2'b00. Hold until bready, then W_IDLE, bvalid=0.
//  Read FSM R_IDLE -> R_DATA -> R_IDLE:
//   R_IDLE: arready=1. On AR handshake go R_DATA.
//     The first beat is valid the next cycle: rdata = mem[araddr], rvalid=1, rlast=(arlen==0).
//   R_DATA: rdata/rresp/rlast stay stable while rvalid && !rready.
//     On rvalid&&rready: if rlast go R_IDLE (rvalid=0, rlast=0).
//     Otherwise present the next address next cycle, giving 1 beat/cycle under continuous rready.
//  Range: a beat whose address >= MEM_DEPTH is out of range.
//   Write: the beat is not written; err=1.
//   Read: rdata=0, rresp=2'b10 for that beat only.
//   The address counter is ADDR_WIDTH wide and does not wrap to 0 within a burst.
//  Simultaneous write and read of the same word in one cycle: the read returns the old data.
//  Burst length is awlen+1 / arlen+1 in 1..256. Channels never block each other.
// TESTING
//  Single write awaddr=5, wdata=32'hA5A5_0001, wstrb=4'hF, wlast -> bresp=00.
//   Read araddr=5, arlen=0 -> rdata=32'hA5A5_0001, rlast=1, rresp=00.
//  Write burst awaddr=16, awlen=3, data 1..4 -> bresp=00.
//   Read araddr=16, arlen=3, rready=1 -> 4 consecutive beats 1,2,3,4; rlast only on beat 4.
//  Strobes: mem[7]=32'hFFFF_FFFF; write 32'h0, wstrb=4'b0101 -> read mem[7]=32'hFF00_FF00.
//  Backpressure: read burst arlen=2 with rready toggling 1/0 -> each beat held stable until accepted.
//   No beat is lost or duplicated.
//  Errors: awaddr=MEM_DEPTH-1, awlen=1 -> beat 0 written, beat 1 dropped, bresp=10.
//   Early wlast on beat 1 of awlen=3 -> bresp=10.
//   Read araddr=MEM_DEPTH -> rdata=0, rresp=10.
//  Reset mid read burst (after 2 of 4 beats): rvalid=0 immediately.
//   After release arready=1 and a new burst completes correctly.

Source files
------------

// File: rtl/axi_burst_mem_slave.sv
// Word-addressed AXI4-style memory slave with INCR bursts, byte strobes and SLVERR responses.
// Write (AW/W/B) and read (AR/R) channels run as independent FSMs at one beat per cycle.
module axi_burst_mem_slave #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_DEPTH  = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ADDR_WIDTH-1:0]     awaddr,
    input  logic [7:0]                awlen,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   wstrb,
    input  logic                      wvalid,
    output logic                      wready,
    input  logic                      wlast,
    output logic [1:0]                bresp,
    output logic                      bvalid,
    input  logic                      bready,
    input  logic [ADDR_WIDTH-1:0]     araddr,
    input  logic [7:0]                arlen,
    input  logic                      arvalid,
    output logic                      arready,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic [1:0]                rresp,
    output logic                      rvalid,
    input  logic                      rready,
    output logic                      rlast
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // ---------------- write channel ----------------
    w_state_t              w_state, w_state_n;
    logic [ADDR_WIDTH-1:0] waddr, waddr_n;
    logic [7:0]            wlen, wlen_n;
    logic [8:0]            wcnt, wcnt_n;
    logic                  werr, werr_n;
    logic [1:0]            bresp_n;
    logic                  awready_n, wready_n, bvalid_n;
    logic                  mem_we_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state <= W_IDLE;
            waddr   <= '0;
            wlen    <= '0;
            wcnt    <= '0;
            werr    <= 1'b0;
            bresp   <= RESP_OKAY;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
        end else begin
            w_state <= w_state_n;
            waddr   <= waddr_n;
            wlen    <= wlen_n;
            wcnt    <= wcnt_n;
            werr    <= werr_n;
            bresp   <= bresp_n;
            awready <= awready_n;
            wready  <= wready_n;
            bvalid  <= bvalid_n;
        end
    end

    // Beats beyond awlen+1 stop advancing the counter, so wcnt never exceeds 256.
    always_comb begin
        w_state_n = w_state;
        waddr_n   = waddr;
        wlen_n    = wlen;
        wcnt_n    = wcnt;
        werr_n    = werr;
        bresp_n   = bresp;
        mem_we_c  = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (awvalid && awready) begin
                    waddr_n   = awaddr;
                    wlen_n    = awlen;
                    wcnt_n    = '0;
                    werr_n    = 1'b0;
                    w_state_n = W_DATA;
                end
            end
            W_DATA: begin
                if (wvalid && wready) begin
                    if (wcnt > {1'b0, wlen}) begin
                        werr_n = 1'b1;
                    end else begin
                        if (waddr < DEPTH_A) mem_we_c = 1'b1;
                        else                 werr_n   = 1'b1;
                        waddr_n = waddr + ADDR_WIDTH'(1);
                        wcnt_n  = wcnt + 9'd1;
                    end
                    if (wlast) begin
                        if (wcnt != {1'b0, wlen}) werr_n = 1'b1;
                        bresp_n   = werr_n ? RESP_SLVERR : RESP_OKAY;
                        w_state_n = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (bvalid && bready) begin
                    bresp_n   = RESP_OKAY;
                    w_state_n = W_IDLE;
                end
            end
            default: w_state_n = W_IDLE;
        endcase
        awready_n = (w_state_n == W_IDLE);
        wready_n  = (w_state_n == W_DATA);
        bvalid_n  = (w_state_n == W_RESP);
    end

    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wstrb[i]) mem[waddr[IDX_W-1:0]][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    // ---------------- read channel ----------------
    r_state_t              r_state, r_state_n;
    logic [ADDR_WIDTH-1:0] raddr, raddr_n;
    logic [7:0]            rcnt, rcnt_n;
    logic [DATA_WIDTH-1:0] rdata_n;
    logic [1:0]            rresp_n;
    logic                  rvalid_n, rlast_n, arready_n;
    logic [ADDR_WIDTH-1:0] rd_addr_c;
    logic                  rd_load_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= R_IDLE;
            raddr   <= '0;
            rcnt    <= '0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            arready <= 1'b0;
        end else begin
            r_state <= r_state_n;
            raddr   <= raddr_n;
            rcnt    <= rcnt_n;
            rdata   <= rdata_n;
            rresp   <= rresp_n;
            rvalid  <= rvalid_n;
            rlast   <= rlast_n;
            arready <= arready_n;
        end
    end

    // rcnt holds the number of beats still to come after the one on the bus.
    always_comb begin
        r_state_n = r_state;
        raddr_n   = raddr;
        rcnt_n    = rcnt;
        rdata_n   = rdata;
        rresp_n   = rresp;
        rvalid_n  = rvalid;
        rlast_n   = rlast;
        rd_addr_c = raddr;
        rd_load_c = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (arvalid && arready) begin
                    rd_addr_c = araddr;
                    raddr_n   = araddr;
                    rcnt_n    = arlen;
                    rlast_n   = (arlen == 8'd0);
                    rd_load_c = 1'b1;
                    r_state_n = R_DATA;
                end
            end
            R_DATA: begin
                if (rvalid && rready) begin
                    if (rlast) begin
                        rvalid_n  = 1'b0;
                        rlast_n   = 1'b0;
                        rdata_n   = '0;
                        rresp_n   = RESP_OKAY;
                        r_state_n = R_IDLE;
                    end else begin
                        rd_addr_c = raddr + ADDR_WIDTH'(1);
                        raddr_n   = rd_addr_c;
                        rcnt_n    = rcnt - 8'd1;
                        rlast_n   = (rcnt == 8'd1);
                        rd_load_c = 1'b1;
                    end
                end
            end
            default: r_state_n = R_IDLE;
        endcase
        if (rd_load_c) begin
            rvalid_n = 1'b1;
            if (rd_addr_c < DEPTH_A) begin
                rdata_n = mem[rd_addr_c[IDX_W-1:0]];
                rresp_n = RESP_OKAY;
            end else begin
                rdata_n = '0;
                rresp_n = RESP_SLVERR;
            end
        end
        arready_n = (r_state_n == R_IDLE);
    end

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// Scoreboard bench for axi_burst_mem_slave: directed bursts push expected B/R responses,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_axi_burst_mem_slave;

    localparam int unsigned DEPTH = 1024;

    logic        clk, rst_n;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, wlast;
    logic [1:0]  bresp, rresp;
    logic        bvalid, bready, arvalid, arready, rvalid, rready, rlast;

    axi_burst_mem_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready), .wlast(wlast),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready), .rlast(rlast)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_beat_t;

    r_beat_t     r_exp[$];
    logic [1:0]  b_exp[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          r_seen   = 0;
    bit          rr_toggle = 0;
    logic [31:0] wb_data [8];
    logic [3:0]  wb_strb [8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic timeout(input string name);
        n_checks++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // rready either held high or toggled every cycle for backpressure
    initial begin
        rready = 1'b1;
        forever begin
            @(posedge clk);
            #1 rready = rr_toggle ? ~rready : 1'b1;
        end
    end

    // Monitor: compare B and R at the negedge before the accepting posedge
    initial begin
        logic        hold_valid;
        logic [34:0] held;
        r_beat_t     e;
        logic [1:0]  eb;
        hold_valid = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_valid = 1'b0;
            end else begin
                if (bvalid && bready) begin
                    if (b_exp.size() == 0) begin
                        n_checks++;
                        $display("FAIL b_unexpected: got bresp %0h with nothing expected", bresp);
                    end else begin
                        eb = b_exp.pop_front();
                        check("bresp", 64'(bresp), 64'(eb));
                    end
                end
                if (rvalid) begin
                    if (hold_valid) check("r_stable", 64'({rdata, rresp, rlast}), 64'(held));
                    if (rready) begin
                        hold_valid = 1'b0;
                        r_seen++;
                        if (r_exp.size() == 0) begin
                            n_checks++;
                            $display("FAIL r_unexpected: got rdata %0h with nothing expected", rdata);
                        end else begin
                            e = r_exp.pop_front();
                            check("rdata", 64'(rdata), 64'(e.data));
                            check("rresp", 64'(rresp), 64'(e.resp));
                            check("rlast", 64'(rlast), 64'(e.last));
                        end
                    end else begin
                        hold_valid = 1'b1;
                        held = {rdata, rresp, rlast};
                    end
                end else begin
                    hold_valid = 1'b0;
                end
            end
        end
    end

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len,
                            input int nbeats, input logic [1:0] exp_resp);
        bit hs;
        int n;
        awaddr = addr; awlen = len; awvalid = 1'b1;
        hs = 1'b0; n = 0;
        while (!hs && n < 100) begin
            @(negedge clk); hs = awready; @(posedge clk); #1; n++;
        end
        awvalid = 1'b0;
        if (!hs) begin timeout("aw_handshake"); return; end
        b_exp.push_back(exp_resp);
        for (int i = 0; i < nbeats; i++) begin
            wdata = wb_data[i]; wstrb = wb_strb[i]; wlast = (i == nbeats - 1); wvalid = 1'b1;
            hs = 1'b0; n = 0;
            while (!hs && n < 100) begin
                @(negedge clk); hs = wready; @(posedge clk); #1; n++;
            end
            if (!hs) timeout("w_handshake");
        end
        wvalid = 1'b0; wlast = 1'b0;
        n = 0;
        while (b_exp.size() != 0 && n < 100) begin @(posedge clk); n++; end
        if (b_exp.size() != 0) begin timeout("b_response"); b_exp.delete(); end
        #1;
    endtask

    task automatic exp_r(input logic [31:0] d, input logic [1:0] resp, input logic last);
        r_beat_t e;
        e.data = d; e.resp = resp; e.last = last;
        r_exp.push_back(e);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input bit drain);
        bit hs;
        int n;
        araddr = addr; arlen = len; arvalid = 1'b1;
        hs = 1'b0; n = 0;
        while (!hs && n < 100) begin
            @(negedge clk); hs = arready; @(posedge clk); #1; n++;
        end
        arvalid = 1'b0;
        if (!hs) begin timeout("ar_handshake"); r_exp.delete(); return; end
        if (drain) begin
            n = 0;
            while (r_exp.size() != 0 && n < 600) begin @(posedge clk); n++; end
            if (r_exp.size() != 0) begin timeout("r_beats"); r_exp.delete(); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int n;
        int seen0;
        rst_n = 1'b0;
        awaddr = '0; awlen = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        araddr = '0; arlen = '0; arvalid = 1'b0;

        // Reset state: every output low
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 64'({awready, wready, bvalid, bresp, arready, rvalid, rresp, rlast, rdata}), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", 64'({awready, arready}), 64'(2'b11));

        // Single write / read
        wb_data[0] = 32'hA5A5_0001; wb_strb[0] = 4'hF;
        do_write(32'd5, 8'd0, 1, 2'b00);
        exp_r(32'hA5A5_0001, 2'b00, 1'b1);
        do_read(32'd5, 8'd0, 1'b1);

        // Four-beat burst
        for (int i = 0; i < 4; i++) begin wb_data[i] = 32'(i + 1); wb_strb[i] = 4'hF; end
        do_write(32'd16, 8'd3, 4, 2'b00);
        for (int i = 0; i < 4; i++) exp_r(32'(i + 1), 2'b00, i == 3);
        do_read(32'd16, 8'd3, 1'b1);

        // Byte strobes
        wb_data[0] = 32'hFFFF_FFFF; wb_strb[0] = 4'hF;
        do_write(32'd7, 8'd0, 1, 2'b00);
        wb_data[0] = 32'h0000_0000; wb_strb[0] = 4'b0101;
        do_write(32'd7, 8'd0, 1, 2'b00);
        exp_r(32'hFF00_FF00, 2'b00, 1'b1);
        do_read(32'd7, 8'd0, 1'b1);

        // Read backpressure with toggling rready
        wb_data[0] = 32'h11; wb_data[1] = 32'h22; wb_data[2] = 32'h33;
        for (int i = 0; i < 3; i++) wb_strb[i] = 4'hF;
        do_write(32'd60, 8'd2, 3, 2'b00);
        rr_toggle = 1'b1;
        exp_r(32'h11, 2'b00, 1'b0); exp_r(32'h22, 2'b00, 1'b0); exp_r(32'h33, 2'b00, 1'b1);
        do_read(32'd60, 8'd2, 1'b1);
        rr_toggle = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Burst crossing the top of memory: second beat dropped
        wb_data[0] = 32'hDEAD_0001; wb_data[1] = 32'hDEAD_0002;
        wb_strb[0] = 4'hF; wb_strb[1] = 4'hF;
        do_write(32'(DEPTH - 1), 8'd1, 2, 2'b10);
        exp_r(32'hDEAD_0001, 2'b00, 1'b0); exp_r(32'h0, 2'b10, 1'b1);
        do_read(32'(DEPTH - 1), 8'd1, 1'b1);

        // Early wlast on beat 1 of a four-beat burst
        wb_data[0] = 32'hC1; wb_data[1] = 32'hC2;
        do_write(32'd40, 8'd3, 2, 2'b10);
        exp_r(32'hC1, 2'b00, 1'b0); exp_r(32'hC2, 2'b00, 1'b1);
        do_read(32'd40, 8'd1, 1'b1);

        // Extra beat past awlen is dropped
        wb_data[0] = 32'hE1; wb_data[1] = 32'hE2;
        do_write(32'd50, 8'd0, 2, 2'b10);
        exp_r(32'hE1, 2'b00, 1'b1);
        do_read(32'd50, 8'd0, 1'b1);

        // Out-of-range read
        exp_r(32'h0, 2'b10, 1'b1);
        do_read(32'(DEPTH), 8'd0, 1'b1);

        // Reset in the middle of a read burst
        for (int i = 0; i < 4; i++) begin wb_data[i] = 32'h50 + 32'(i + 1); wb_strb[i] = 4'hF; end
        do_write(32'd32, 8'd3, 4, 2'b00);
        seen0 = r_seen;
        for (int i = 0; i < 4; i++) exp_r(32'h50 + 32'(i + 1), 2'b00, i == 3);
        do_read(32'd32, 8'd3, 1'b0);
        n = 0;
        while (r_seen < seen0 + 2 && n < 100) begin @(posedge clk); n++; end
        if (r_seen < seen0 + 2) timeout("mid_burst_beats");
        #1 rst_n = 1'b0;
        #1 check("reset_mid_burst", 64'({rvalid, rlast, arready, awready}), 64'(0));
        check("beats_before_reset", 64'(r_seen - seen0), 64'(2));
        r_exp.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("arready_after_release", 64'(arready), 64'(1));
        for (int i = 0; i < 4; i++) begin wb_data[i] = 32'h70 + 32'(i + 1); wb_strb[i] = 4'hF; end
        do_write(32'd32, 8'd3, 4, 2'b00);
        for (int i = 0; i < 4; i++) exp_r(32'h70 + 32'(i + 1), 2'b00, i == 3);
        do_read(32'd32, 8'd3, 1'b1);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
